// File: rtl/logarithmic_afpm.sv
// Approximate FP16 multiplier (Mitchell logarithmic method) with byte-serial
// operand load and product readout over a free-running 5-state frame.
module logarithmic_afpm (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    typedef enum logic [2:0] {
        LOAD_LO,
        LOAD_HI,
        CALC,
        OUT_LO,
        OUT_HI
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] a_q, a_d;
    logic [15:0] b_q, b_d;
    logic [15:0] r_q, r_d;

    logic [4:0]         a_exp, b_exp;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic               sign;
    logic signed [16:0] sum_s;
    logic [15:0]        f_res;

    // Mitchell product: adding the biased {exp,man} fields approximates the log-domain sum.
    always_comb begin
        a_exp  = a_q[14:10];
        b_exp  = b_q[14:10];
        a_nan  = (a_exp == 5'd31) && (a_q[9:0] != 10'd0);
        b_nan  = (b_exp == 5'd31) && (b_q[9:0] != 10'd0);
        a_inf  = (a_exp == 5'd31) && (a_q[9:0] == 10'd0);
        b_inf  = (b_exp == 5'd31) && (b_q[9:0] == 10'd0);
        a_zero = (a_exp == 5'd0);
        b_zero = (b_exp == 5'd0);
        sign   = a_q[15] ^ b_q[15];
        sum_s  = $signed({2'b00, a_q[14:0]}) + $signed({2'b00, b_q[14:0]}) - 17'sd15360;

        if (a_nan || b_nan)
            f_res = 16'h7E00;
        else if ((a_inf && b_zero) || (b_inf && a_zero))
            f_res = 16'h7E00;
        else if (a_inf || b_inf)
            f_res = {sign, 15'h7C00};
        else if (a_zero || b_zero)
            f_res = {sign, 15'h0000};
        else if (sum_s < 17'sd1024)
            f_res = {sign, 15'h0000};
        else if (sum_s >= 17'sd31744)
            f_res = {sign, 15'h7C00};
        else
            f_res = {sign, sum_s[14:0]};
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        r_d     = r_q;
        case (state_q)
            LOAD_LO: begin
                a_d[7:0] = ui_in;
                b_d[7:0] = uio_in;
                state_d  = LOAD_HI;
            end
            LOAD_HI: begin
                a_d[15:8] = ui_in;
                b_d[15:8] = uio_in;
                state_d   = CALC;
            end
            CALC: begin
                r_d     = f_res;
                state_d = OUT_LO;
            end
            OUT_LO:  state_d = OUT_HI;
            OUT_HI:  state_d = LOAD_LO;
            default: state_d = LOAD_LO;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD_LO;
            a_q     <= '0;
            b_q     <= '0;
            r_q     <= '0;
        end else if (ena) begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            r_q     <= r_d;
        end
    end

    always_comb begin
        case (state_q)
            OUT_LO:  uo_out = r_q[7:0];
            OUT_HI:  uo_out = r_q[15:8];
            default: uo_out = 8'h00;
        endcase
    end

    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_logarithmic_afpm.sv
// Self-checking bench for logarithmic_afpm: directed vectors, reset/ena cases,
// and randomized frames against a field-level reference model.
module tb_logarithmic_afpm;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int unsigned n_cmp;
    int unsigned n_err;

    logarithmic_afpm dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: decode operands into integer fields and apply the product rules.
    function automatic logic [15:0] ref_mul(input logic [15:0] a, input logic [15:0] b);
        int ea, eb, ma, mb, s;
        bit sg, nan_a, nan_b, inf_a, inf_b;
        logic [15:0] sv;
        ea = int'(a[14:10]);  ma = int'(a[9:0]);
        eb = int'(b[14:10]);  mb = int'(b[9:0]);
        sg = a[15] ^ b[15];
        nan_a = (ea == 31) && (ma != 0);
        nan_b = (eb == 31) && (mb != 0);
        inf_a = (ea == 31) && (ma == 0);
        inf_b = (eb == 31) && (mb == 0);
        s = (ea + eb - 15) * 1024 + ma + mb;
        if (nan_a || nan_b)                            return 16'h7E00;
        if ((inf_a && eb == 0) || (inf_b && ea == 0))  return 16'h7E00;
        if (inf_a || inf_b)                            return sg ? 16'hFC00 : 16'h7C00;
        if (ea == 0 || eb == 0)                        return sg ? 16'h8000 : 16'h0000;
        if (s < 1024)                                  return sg ? 16'h8000 : 16'h0000;
        if (s >= 31 * 1024)                            return sg ? 16'hFC00 : 16'h7C00;
        sv = 16'(s);
        return {sg, sv[14:0]};
    endfunction

    // One full frame starting at a negedge with the DUT in LOAD_LO.
    // freeze: 0 none, 1 hold ena low before the high-byte edge (with junk on the
    // inputs), 2 hold ena low while the low product byte is presented.
    task automatic run_frame(input string tag, input logic [15:0] a, input logic [15:0] b,
                             input logic [15:0] exp, input int freeze);
        ui_in  = a[7:0];
        uio_in = b[7:0];
        @(posedge clk);
        @(negedge clk);
        check({tag, "_ld"}, {8'h00, uo_out}, 16'h0000);
        ui_in  = a[15:8];
        uio_in = b[15:8];
        if (freeze == 1) begin
            ena    = 1'b0;
            ui_in  = 8'hA5;
            uio_in = 8'h5A;
            repeat (3) @(posedge clk);
            @(negedge clk);
            ena    = 1'b1;
            ui_in  = a[15:8];
            uio_in = b[15:8];
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_calc"}, {8'h00, uo_out}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
        check({tag, "_lo"}, {8'h00, uo_out}, {8'h00, exp[7:0]});
        if (freeze == 2) begin
            ena = 1'b0;
            for (int unsigned i = 0; i < 3; i++) begin
                @(posedge clk);
                @(negedge clk);
                check({tag, "_frz"}, {8'h00, uo_out}, {8'h00, exp[7:0]});
            end
            ena = 1'b1;
        end
        @(posedge clk);
        @(negedge clk);
        check({tag, "_hi"}, {8'h00, uo_out}, {8'h00, exp[15:8]});
        check({tag, "_uio"}, {uio_out, uio_oe}, 16'h0000);
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [15:0] rand_operand();
        logic [15:0] v;
        int unsigned sel;
        v   = 16'($urandom);
        sel = $urandom_range(0, 7);
        if (sel == 0) v[14:10] = 5'd0;
        else if (sel == 1) v[14:10] = 5'd31;
        else if (sel == 2) v[9:0] = 10'd0;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] ra, rb;
        n_cmp  = 0;
        n_err  = 0;
        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_uo", {8'h00, uo_out}, 16'h0000);
        rst_n = 1'b1;

        run_frame("mul_1p5x3",  16'h3E00, 16'h4200, 16'h4400, 0);
        run_frame("mul_2xm3",   16'h4000, 16'hC200, 16'hC600, 0);
        run_frame("zero",       16'h0000, 16'h4200, 16'h0000, 0);
        run_frame("ovf",        16'h7800, 16'h7800, 16'h7C00, 0);
        run_frame("inf_x_zero", 16'h7C00, 16'h0000, 16'h7E00, 0);
        run_frame("inf_x_m1",   16'h7C00, 16'hBC00, 16'hFC00, 0);
        run_frame("nan",        16'h7C01, 16'h3C00, 16'h7E00, 0);
        run_frame("unf",        16'h0400, 16'h0400, 16'h0000, 0);

        // Aborted frame: reset during LOAD_HI.
        ui_in  = 8'hFF;
        uio_in = 8'hFF;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_mid_uo", {8'h00, uo_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        run_frame("post_rst", 16'h3C00, 16'h3C00, 16'h3C00, 0);

        // Reset while a product byte is being presented must blank it at once.
        ui_in  = 8'h00;
        uio_in = 8'h40;
        @(posedge clk);
        @(negedge clk);
        ui_in  = 8'h44;
        uio_in = 8'h44;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b0;
        #1 check("rst_out_uo", {8'h00, uo_out}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        run_frame("frz_load", 16'h4100, 16'h3A80, ref_mul(16'h4100, 16'h3A80), 1);
        run_frame("frz_out",  16'h4555, 16'hC3AA, ref_mul(16'h4555, 16'hC3AA), 2);

        for (int unsigned i = 0; i < 300; i++) begin
            ra = rand_operand();
            rb = rand_operand();
            run_frame("rand", ra, rb, ref_mul(ra, rb), (i % 50 == 7) ? 2 : ((i % 50 == 23) ? 1 : 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
